// File: rtl/inst_loader.sv
// Framed byte-stream loader: parses sync/count/little-endian words and writes them
// into instruction memory, holding the core in reset until the whole program is in.
module inst_loader #(
  parameter int unsigned PC_SIZE       = 10,
  parameter int unsigned INST_MEM_SIZE = 1024,
  parameter logic [7:0]  SYNC_BYTE     = 8'hA5
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               rx_valid,
  input  logic [7:0]         rx_byte,
  output logic               rx_ready,
  output logic [31:0]        instruction_in,
  output logic [PC_SIZE-1:0] PC_write,
  output logic               reset_IF_memory,
  output logic               core_reset,
  output logic               busy,
  output logic               done,
  output logic               error
);

  typedef enum logic [2:0] {
    IDLE,
    CNT_LO,
    CNT_HI,
    BYTE,
    WRITE,
    DONE,
    ERROR
  } state_t;

  localparam logic [15:0] MAX_WORDS = 16'(INST_MEM_SIZE / 4);

  state_t      state, state_next;
  logic [7:0]  count_lo;
  logic [15:0] remaining;
  logic [1:0]  byte_idx;
  logic        xfer;
  logic [15:0] count_full;
  logic        count_bad;

  // rx_ready depends only on state, so the handshake is derived directly from it
  assign xfer       = rx_valid && (state != WRITE);
  assign count_full = {rx_byte, count_lo};
  assign count_bad  = (count_full == 16'd0) || (count_full > MAX_WORDS);

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next      = state;
    rx_ready        = 1'b1;
    reset_IF_memory = 1'b0;
    core_reset      = 1'b1;
    busy            = 1'b0;
    done            = 1'b0;
    error           = 1'b0;
    case (state)
      IDLE: begin
        if (xfer && rx_byte == SYNC_BYTE) state_next = CNT_LO;
      end
      CNT_LO: begin
        busy = 1'b1;
        if (xfer) state_next = CNT_HI;
      end
      CNT_HI: begin
        busy = 1'b1;
        if (xfer) state_next = count_bad ? ERROR : BYTE;
      end
      BYTE: begin
        busy = 1'b1;
        if (xfer && byte_idx == 2'd3) state_next = WRITE;
      end
      WRITE: begin
        busy            = 1'b1;
        rx_ready        = 1'b0;
        reset_IF_memory = 1'b1;
        state_next      = (remaining == 16'd1) ? DONE : BYTE;
      end
      DONE: begin
        done       = 1'b1;
        core_reset = 1'b0;
        if (xfer && rx_byte == SYNC_BYTE) state_next = CNT_LO;
      end
      ERROR: begin
        error = 1'b1;
        if (xfer && rx_byte == SYNC_BYTE) state_next = CNT_LO;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      count_lo       <= '0;
      remaining      <= '0;
      byte_idx       <= '0;
      instruction_in <= '0;
      PC_write       <= '0;
    end else begin
      case (state)
        CNT_LO: if (xfer) count_lo <= rx_byte;
        CNT_HI: begin
          if (xfer && !count_bad) begin
            remaining <= count_full;
            byte_idx  <= '0;
            PC_write  <= '0;
          end
        end
        BYTE: begin
          if (xfer) begin
            instruction_in[{byte_idx, 3'b000} +: 8] <= rx_byte;
            byte_idx <= byte_idx + 2'd1;
          end
        end
        WRITE: begin
          remaining <= remaining - 16'd1;
          // hold the address on the final word so it never points past the program
          if (remaining != 16'd1) PC_write <= PC_write + PC_SIZE'(4);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_inst_loader.sv
// Directed bench for inst_loader: nominal, garbage, bad count, max count,
// stall/backpressure and mid-frame reset scenarios.
module tb_inst_loader;

  logic        clock = 1'b0;
  logic        reset;
  logic        rx_valid;
  logic [7:0]  rx_byte;
  logic        rx_ready;
  logic [31:0] instruction_in;
  logic [9:0]  PC_write;
  logic        reset_IF_memory;
  logic        core_reset;
  logic        busy;
  logic        done;
  logic        error;

  int unsigned tests  = 0;
  int unsigned failed = 0;

  logic [31:0] strobe_data [0:1023];
  logic [9:0]  strobe_pc   [0:1023];
  logic        strobe_rdy  [0:1023];
  int unsigned n_strobe = 0;
  int unsigned n0;

  inst_loader #(
    .PC_SIZE      (10),
    .INST_MEM_SIZE(1024),
    .SYNC_BYTE    (8'hA5)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .rx_valid       (rx_valid),
    .rx_byte        (rx_byte),
    .rx_ready       (rx_ready),
    .instruction_in (instruction_in),
    .PC_write       (PC_write),
    .reset_IF_memory(reset_IF_memory),
    .core_reset     (core_reset),
    .busy           (busy),
    .done           (done),
    .error          (error)
  );

  always #5 clock = ~clock;

  always @(negedge clock) begin
    if (reset_IF_memory === 1'b1 && n_strobe < 1024) begin
      strobe_data[n_strobe] = instruction_in;
      strobe_pc[n_strobe]   = PC_write;
      strobe_rdy[n_strobe]  = rx_ready;
      n_strobe              = n_strobe + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [7:0] b);
    int unsigned waited;
    @(negedge clock);
    rx_valid = 1'b1;
    rx_byte  = b;
    waited   = 0;
    while (rx_ready !== 1'b1 && waited < 20) begin
      @(negedge clock);
      waited++;
    end
    if (waited >= 20) check("send_timeout", {31'd0, rx_ready}, 32'd1);
    @(posedge clock);
  endtask

  task automatic send_word(input logic [31:0] w);
    send(w[7:0]);
    send(w[15:8]);
    send(w[23:16]);
    send(w[31:24]);
  endtask

  task automatic idle(input int unsigned n);
    @(negedge clock);
    rx_valid = 1'b0;
    repeat (n) @(negedge clock);
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset    = 1'b1;
    rx_valid = 1'b0;
    @(negedge clock);
    reset = 1'b0;
  endtask

  initial begin
    reset    = 1'b1;
    rx_valid = 1'b0;
    rx_byte  = 8'h00;
    repeat (2) @(negedge clock);
    reset = 1'b0;

    // Reset values
    check("rst_rx_ready",   {31'd0, rx_ready},        32'd1);
    check("rst_strobe",     {31'd0, reset_IF_memory}, 32'd0);
    check("rst_core_reset", {31'd0, core_reset},      32'd1);
    check("rst_busy",       {31'd0, busy},            32'd0);
    check("rst_done",       {31'd0, done},            32'd0);
    check("rst_error",      {31'd0, error},           32'd0);
    check("rst_inst",       instruction_in,           32'h0);
    check("rst_pc",         {22'd0, PC_write},        32'd0);

    // Nominal two-word load
    n0 = n_strobe;
    send(8'hA5); send(8'h02); send(8'h00);
    check("nom_busy", {31'd0, busy}, 32'd1);
    send_word(32'h00000013);
    send_word(32'h00100093);
    @(negedge clock);
    rx_valid = 1'b0;
    check("nom_last_strobe",  {31'd0, reset_IF_memory}, 32'd1);
    check("nom_core_rst_hi",  {31'd0, core_reset},      32'd1);
    @(negedge clock);
    check("nom_done",         {31'd0, done},       32'd1);
    check("nom_core_rst_lo",  {31'd0, core_reset}, 32'd0);
    check("nom_busy_lo",      {31'd0, busy},       32'd0);
    idle(2);
    check("nom_n_strobe", n_strobe - n0,           32'd2);
    check("nom_d0",       strobe_data[n0],         32'h00000013);
    check("nom_pc0",      {22'd0, strobe_pc[n0]},  32'd0);
    check("nom_d1",       strobe_data[n0+1],       32'h00100093);
    check("nom_pc1",      {22'd0, strobe_pc[n0+1]}, 32'd4);

    // Garbage before sync from IDLE
    do_reset();
    n0 = n_strobe;
    send(8'h00); send(8'hFF); send(8'h5A);
    idle(1);
    check("garb_busy", {31'd0, busy}, 32'd0);
    send(8'hA5); send(8'h01); send(8'h00);
    send_word(32'h12345678);
    idle(3);
    check("garb_n_strobe", n_strobe - n0,          32'd1);
    check("garb_d0",       strobe_data[n0],        32'h12345678);
    check("garb_pc0",      {22'd0, strobe_pc[n0]}, 32'd0);
    check("garb_done",     {31'd0, done},          32'd1);

    // Bad counts: 0 and 257
    n0 = n_strobe;
    send(8'hA5); send(8'h00); send(8'h00);
    idle(1);
    check("bad0_error",    {31'd0, error},      32'd1);
    check("bad0_core_rst", {31'd0, core_reset}, 32'd1);
    check("bad0_done",     {31'd0, done},       32'd0);
    send(8'hA5); send(8'h01); send(8'h01);
    idle(1);
    check("bad257_error",    {31'd0, error},      32'd1);
    check("bad257_core_rst", {31'd0, core_reset}, 32'd1);
    check("bad_n_strobe",    n_strobe - n0,       32'd0);
    send(8'hA5);
    idle(0);
    check("bad_err_clear", {31'd0, error}, 32'd0);
    send(8'h01); send(8'h00);
    send_word(32'hCAFEF00D);
    idle(3);
    check("bad_recover_done", {31'd0, done},   32'd1);
    check("bad_recover_data", strobe_data[n0], 32'hCAFEF00D);

    // Maximum count: 256 words, data = word index
    n0 = n_strobe;
    send(8'hA5); send(8'h00); send(8'h01);
    for (int i = 0; i < 256; i++) send_word(32'(i));
    idle(3);
    check("max_n_strobe",  n_strobe - n0,              32'd256);
    check("max_first_pc",  {22'd0, strobe_pc[n0]},     32'd0);
    check("max_mid_data",  strobe_data[n0+100],        32'd100);
    check("max_last_pc",   {22'd0, strobe_pc[n0+255]}, 32'd1020);
    check("max_last_data", strobe_data[n0+255],        32'h000000FF);
    check("max_done",      {31'd0, done},              32'd1);

    // Stall for 7 cycles between bytes 2 and 3, then backpressure on strobe
    n0 = n_strobe;
    send(8'hA5); send(8'h01); send(8'h00);
    send(8'h44); send(8'h33);
    idle(7);
    check("stall_busy",  {31'd0, busy},       32'd1);
    check("stall_ready", {31'd0, rx_ready},   32'd1);
    send(8'h22); send(8'h11);
    idle(3);
    check("stall_data",      strobe_data[n0],         32'h11223344);
    check("stall_strobe_rdy", {31'd0, strobe_rdy[n0]}, 32'd0);

    // Reset mid-frame, with a sync byte offered during reset
    send(8'hA5); send(8'h02); send(8'h00);
    send(8'hAA); send(8'hBB);
    @(negedge clock);
    reset    = 1'b1;
    rx_valid = 1'b1;
    rx_byte  = 8'hA5;
    @(negedge clock);
    reset    = 1'b0;
    rx_valid = 1'b0;
    check("mid_rst_busy",     {31'd0, busy},       32'd0);
    check("mid_rst_pc",       {22'd0, PC_write},   32'd0);
    check("mid_rst_core_rst", {31'd0, core_reset}, 32'd1);
    check("mid_rst_inst",     instruction_in,      32'h0);
    n0 = n_strobe;
    send(8'hA5); send(8'h01); send(8'h00);
    send_word(32'hDEADBEEF);
    idle(3);
    check("fresh_n_strobe", n_strobe - n0,          32'd1);
    check("fresh_data",     strobe_data[n0],        32'hDEADBEEF);
    check("fresh_pc",       {22'd0, strobe_pc[n0]}, 32'd0);
    check("fresh_done",     {31'd0, done},          32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
